// File: rtl/pixel_accumulator_pkg.sv
// Shared pixel-path types: fp_color field layout, unorm8 RGB triple and the gamma-2.0 table entry.
package pixel_accumulator_pkg;

   localparam int FP_EXP_BIAS = 63;
   localparam int FP_MAN_W    = 16;
   localparam int FP_EXP_W    = 7;
   localparam int FP_W        = 1 + FP_EXP_W + FP_MAN_W;
   localparam int UNORM_W     = 8;
   // Smallest exponent whose value still reaches one unorm8 step (2^-8).
   localparam int FP_EXP_MIN  = FP_EXP_BIAS - UNORM_W;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb8;

   // round(sqrt(lin/255)*255) == round(sqrt(lin*255)), built from an integer square root.
   function automatic logic [7:0] gamma_entry(input logic [7:0] lin);
      int x;
      int s;
      int t;
      x = int'(lin) * 32'sd255;
      s = 32'sd0;
      for (int i = 32'sd7; i >= 32'sd0; i--) begin
         t = s + (32'sd1 << i);
         if (t * t <= x) begin
            s = t;
         end else begin
            s = s;
         end
      end
      if (x > s * s + s) begin
         s = s + 32'sd1;
      end else begin
         s = s;
      end
      return 8'(s);
   endfunction

endpackage

// File: rtl/pixel_accumulator_if.sv
// Framebuffer write port: valid/ready request carrying address and RGB888 data, plus frame marker.
interface pixel_accumulator_if
   import pixel_accumulator_pkg::*;
#(
   parameter int ADDR_W = 20
);
   logic              fb_valid;
   logic              fb_ready;
   logic [ADDR_W-1:0] fb_addr;
   rgb8               fb_data;
   logic              frame_done;

   modport master (
      output fb_valid,
      output fb_addr,
      output fb_data,
      output frame_done,
      input  fb_ready
   );

   modport slave (
      input  fb_valid,
      input  fb_addr,
      input  fb_data,
      input  frame_done,
      output fb_ready
   );
endinterface

// File: rtl/fp24_to_unorm8.sv
// Single-channel fp24 {sign, exp bias 63, man16} to unorm8 converter; truncates, clamps at 1.0.
module fp24_to_unorm8
   import pixel_accumulator_pkg::*;
(
   input  logic [FP_W-1:0] fp,
   output logic [7:0]      unorm
);

   logic                  sign_s;
   logic [FP_EXP_W-1:0]   exp_s;
   logic [FP_MAN_W-1:0]   man_s;
   logic [2:0]            shift_s;
   logic [FP_MAN_W+7:0]   scaled_s;

   // Scale the hidden-one mantissa into 8.16 fixed point and keep the integer part.
   always_comb begin
      sign_s   = fp[FP_W-1];
      exp_s    = fp[FP_W-2 -: FP_EXP_W];
      man_s    = fp[FP_MAN_W-1:0];
      shift_s  = 3'(exp_s - 7'(FP_EXP_MIN));
      scaled_s = {7'd0, 1'b1, man_s} << shift_s;
      if (sign_s || (exp_s < 7'(FP_EXP_MIN))) begin
         unorm = 8'd0;
      end else if (exp_s >= 7'(FP_EXP_BIAS)) begin
         unorm = 8'd255;
      end else begin
         unorm = scaled_s[FP_MAN_W+7:FP_MAN_W];
      end
   end

endmodule

// File: rtl/pixel_accumulator.sv
// Converts tracer samples to unorm8, box-averages 2^log2_spp samples per pixel, buffers results for
// the framebuffer. Define GAMMA_EN to route averages through a gamma-2.0 ROM; frame_done is registered.
module pixel_accumulator
   import pixel_accumulator_pkg::*;
#(
   parameter  int WIDTH      = 1280,
   parameter  int HEIGHT     = 720,
   parameter  int FIFO_DEPTH = 4,
   localparam int ADDR_W     = $clog2(WIDTH * HEIGHT)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 sample_valid,
   input  logic [3*FP_W-1:0]    sample_color,
   input  logic [10:0]          sample_h,
   input  logic [9:0]           sample_v,
   input  logic [2:0]           log2_spp,
   pixel_accumulator_if.master  fb,
   output logic                 overflow,
   output logic                 seq_err
);

   localparam int                PTR_W     = $clog2(FIFO_DEPTH);
   localparam logic [ADDR_W-1:0] WIDTH_A   = ADDR_W'(WIDTH);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 32'sd1);
   localparam logic [PTR_W:0]    PTR_ONE   = {{PTR_W{1'b0}}, 1'b1};

   logic [7:0]  conv_r_s;
   logic [7:0]  conv_g_s;
   logic [7:0]  conv_b_s;

   logic        s1_valid_r;
   rgb8         s1_rgb_r;
   logic [10:0] s1_h_r;
   logic [9:0]  s1_v_r;
   logic [2:0]  s1_spp_r;

   logic [6:0]  count_r;
   logic [2:0]  spp_r;
   logic [10:0] h_r;
   logic [9:0]  v_r;
   logic [14:0] sum_r_r;
   logic [14:0] sum_g_r;
   logic [14:0] sum_b_r;
   logic        seq_err_r;

   logic [7:0]  count_inc_s;
   logic [6:0]  count_n_s;
   logic [2:0]  spp_n_s;
   logic [10:0] h_n_s;
   logic [9:0]  v_n_s;
   logic [14:0] sum_r_n_s;
   logic [14:0] sum_g_n_s;
   logic [14:0] sum_b_n_s;
   logic        done_s;
   logic        seq_hit_s;
   rgb8         avg_s;
   logic [ADDR_W-1:0] addr_s;

   logic              push_valid_r;
   logic [ADDR_W-1:0] push_addr_r;
   rgb8               push_rgb_r;
   rgb8               push_data_s;

   logic [PTR_W:0]    wr_ptr_r;
   logic [PTR_W:0]    rd_ptr_r;
   logic [ADDR_W-1:0] fifo_addr_r [FIFO_DEPTH];
   rgb8               fifo_data_r [FIFO_DEPTH];
   logic              empty_s;
   logic              full_s;
   logic              pop_s;
   logic              push_ok_s;
   logic [ADDR_W-1:0] head_addr_s;
   logic              overflow_r;
   logic              frame_done_r;

   fp24_to_unorm8 u_conv_r (.fp(sample_color[3*FP_W-1 -: FP_W]), .unorm(conv_r_s));
   fp24_to_unorm8 u_conv_g (.fp(sample_color[2*FP_W-1 -: FP_W]), .unorm(conv_g_s));
   fp24_to_unorm8 u_conv_b (.fp(sample_color[FP_W-1:0]),         .unorm(conv_b_s));

   // Conversion stage register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_r <= 1'b0;
         s1_rgb_r   <= '0;
         s1_h_r     <= 11'd0;
         s1_v_r     <= 10'd0;
         s1_spp_r   <= 3'd0;
      end else begin
         s1_valid_r <= sample_valid;
         s1_rgb_r   <= {conv_r_s, conv_g_s, conv_b_s};
         s1_h_r     <= sample_h;
         s1_v_r     <= sample_v;
         s1_spp_r   <= log2_spp;
      end
   end

   // Accumulator next state: start, extend or restart the current pixel and detect completion.
   always_comb begin
      count_n_s   = count_r;
      spp_n_s     = spp_r;
      h_n_s       = h_r;
      v_n_s       = v_r;
      sum_r_n_s   = sum_r_r;
      sum_g_n_s   = sum_g_r;
      sum_b_n_s   = sum_b_r;
      seq_hit_s   = 1'b0;
      done_s      = 1'b0;
      count_inc_s = {1'b0, count_r} + 8'd1;
      if (s1_valid_r) begin
         if (count_r == 7'd0) begin
            spp_n_s     = s1_spp_r;
            h_n_s       = s1_h_r;
            v_n_s       = s1_v_r;
            sum_r_n_s   = {7'd0, s1_rgb_r.r};
            sum_g_n_s   = {7'd0, s1_rgb_r.g};
            sum_b_n_s   = {7'd0, s1_rgb_r.b};
            count_inc_s = 8'd1;
         end else if ((s1_h_r == h_r) && (s1_v_r == v_r)) begin
            sum_r_n_s   = sum_r_r + {7'd0, s1_rgb_r.r};
            sum_g_n_s   = sum_g_r + {7'd0, s1_rgb_r.g};
            sum_b_n_s   = sum_b_r + {7'd0, s1_rgb_r.b};
         end else begin
            seq_hit_s   = 1'b1;
            h_n_s       = s1_h_r;
            v_n_s       = s1_v_r;
            sum_r_n_s   = {7'd0, s1_rgb_r.r};
            sum_g_n_s   = {7'd0, s1_rgb_r.g};
            sum_b_n_s   = {7'd0, s1_rgb_r.b};
            count_inc_s = 8'd1;
         end
         // The count is widened by one bit so that 128 samples (spp 7) compare correctly.
         if (count_inc_s == (8'd1 << spp_n_s)) begin
            done_s    = 1'b1;
            count_n_s = 7'd0;
         end else begin
            count_n_s = count_inc_s[6:0];
         end
      end else begin
         done_s = 1'b0;
      end
   end

   // Averages and framebuffer address of the pixel completing this cycle.
   always_comb begin
      avg_s.r = 8'(sum_r_n_s >> spp_n_s);
      avg_s.g = 8'(sum_g_n_s >> spp_n_s);
      avg_s.b = 8'(sum_b_n_s >> spp_n_s);
      addr_s  = ADDR_W'(v_n_s) * WIDTH_A + ADDR_W'(h_n_s);
   end

   // Accumulation stage register and completed-pixel push register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r      <= 7'd0;
         spp_r        <= 3'd0;
         h_r          <= 11'd0;
         v_r          <= 10'd0;
         sum_r_r      <= 15'd0;
         sum_g_r      <= 15'd0;
         sum_b_r      <= 15'd0;
         seq_err_r    <= 1'b0;
         push_valid_r <= 1'b0;
         push_addr_r  <= '0;
         push_rgb_r   <= '0;
      end else begin
         count_r      <= count_n_s;
         spp_r        <= spp_n_s;
         h_r          <= h_n_s;
         v_r          <= v_n_s;
         sum_r_r      <= sum_r_n_s;
         sum_g_r      <= sum_g_n_s;
         sum_b_r      <= sum_b_n_s;
         seq_err_r    <= seq_err_r | seq_hit_s;
         push_valid_r <= done_s;
         if (done_s) begin
            push_addr_r <= addr_s;
            push_rgb_r  <= avg_s;
         end
      end
   end

`ifdef GAMMA_EN
   logic [7:0] gamma_rom_s [256];
   for (genvar gi = 32'sd0; gi < 32'sd256; gi++) begin : g_gamma_rom
      assign gamma_rom_s[gi] = gamma_entry(8'(gi));
   end
   assign push_data_s = {gamma_rom_s[push_rgb_r.r], gamma_rom_s[push_rgb_r.g], gamma_rom_s[push_rgb_r.b]};
`else
   assign push_data_s = push_rgb_r;
`endif

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   always_comb begin
      empty_s     = (wr_ptr_r == rd_ptr_r);
      full_s      = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                    (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
      pop_s       = !empty_s && fb.fb_ready;
      push_ok_s   = push_valid_r && (!full_s || pop_s);
      head_addr_s = fifo_addr_r[rd_ptr_r[PTR_W-1:0]];
   end

   // Output FIFO storage, pointers and sticky/pulse status.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r     <= '0;
         rd_ptr_r     <= '0;
         overflow_r   <= 1'b0;
         frame_done_r <= 1'b0;
         for (int i = 32'sd0; i < FIFO_DEPTH; i++) begin
            fifo_addr_r[i] <= '0;
            fifo_data_r[i] <= '0;
         end
      end else begin
         if (push_ok_s) begin
            fifo_addr_r[wr_ptr_r[PTR_W-1:0]] <= push_addr_r;
            fifo_data_r[wr_ptr_r[PTR_W-1:0]] <= push_data_s;
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         overflow_r   <= overflow_r | (push_valid_r & full_s & ~pop_s);
         frame_done_r <= pop_s & (head_addr_s == LAST_ADDR);
      end
   end

   assign fb.fb_valid   = !empty_s;
   assign fb.fb_addr    = head_addr_s;
   assign fb.fb_data    = fifo_data_r[rd_ptr_r[PTR_W-1:0]];
   assign fb.frame_done = frame_done_r;
   assign overflow      = overflow_r;
   assign seq_err       = seq_err_r;

endmodule
